// File: rtl/enemy_move_pacer.sv
// Step pacer for the enemy formation: emits the periodic move strobe, reverses
// direction and drops a row at screen edges, and shortens the period on each kill.
module enemy_move_pacer #(
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned BASE_PERIOD = 2_500_000,
  parameter int unsigned MIN_PERIOD  = 250_000,
  parameter int unsigned SPEED_STEP  = 50_000,
  parameter logic [10:0] X_MIN       = 11'd8,
  parameter logic [10:0] X_MAX       = 11'd600
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [10:0]      posx_in,
  input  logic             speedup,
  output logic             mueva,
  output logic             dir,
  output logic             bajar,
  output logic [CNT_W-1:0] period,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] P_BASE = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] P_STEP = CNT_W'(SPEED_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_mueva, w_mueva_nxt;
  logic             r_bajar, w_bajar_nxt;
  logic             r_dir, w_dir_nxt;

  logic [CNT_W-1:0] w_reload;
  logic [CNT_W:0]   w_dec;
  logic [CNT_W-1:0] w_period_sat;
  logic             w_tick;
  logic             w_edge;

  assign w_reload = r_period - CNT_W'(1);
  assign w_tick   = (r_cnt == '0);
  assign w_edge   = (!r_dir && (posx_in >= X_MAX)) || (r_dir && (posx_in <= X_MIN));

  // One extra bit so a period below SPEED_STEP shows up as negative instead of wrapping.
  assign w_dec        = {1'b0, r_period} - {1'b0, P_STEP};
  assign w_period_sat = (w_dec[CNT_W] || (w_dec < {1'b0, P_MIN})) ? P_MIN : w_dec[CNT_W-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mueva_nxt  = 1'b0;
    w_bajar_nxt  = 1'b0;
    w_dir_nxt    = r_dir;
    w_period_nxt = speedup ? w_period_sat : r_period;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = w_reload;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (!w_tick) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt = w_reload;
          // The drop strobe replaces the move strobe, so spacing stays one period.
          if (w_edge) begin
            w_state_nxt = DROP;
            w_bajar_nxt = 1'b1;
            w_dir_nxt   = !r_dir;
          end else begin
            w_mueva_nxt = 1'b1;
          end
        end
      end
      DROP: begin
        w_cnt_nxt   = w_tick ? w_reload : r_cnt - CNT_W'(1);
        w_state_nxt = enable ? RUN : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mueva  <= 1'b0;
      r_bajar  <= 1'b0;
      r_dir    <= 1'b0;
      r_period <= P_BASE;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mueva  <= w_mueva_nxt;
      r_bajar  <= w_bajar_nxt;
      r_dir    <= w_dir_nxt;
      r_period <= w_period_nxt;
    end
  end

  assign mueva     = r_mueva;
  assign bajar     = r_bajar;
  assign dir       = r_dir;
  assign period    = r_period;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_enemy_move_pacer.sv
// Directed bench for enemy_move_pacer: strobe timing, edge reversal, speed-up,
// enable freeze and reset, checked against a strobe-schedule model every cycle.
module tb_enemy_move_pacer;

  localparam int CNT_W = 22;
  localparam int BASE  = 8;
  localparam int MINP  = 4;
  localparam int STEP  = 3;
  localparam int XMIN  = 10;
  localparam int XMAX  = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [10:0]      posx_in;
  logic             speedup;
  logic             mueva;
  logic             dir;
  logic             bajar;
  logic [CNT_W-1:0] period;
  logic [1:0]       state_dbg;

  enemy_move_pacer #(
    .CNT_W(CNT_W), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .SPEED_STEP(STEP),
    .X_MIN(11'(XMIN)), .X_MAX(11'(XMAX))
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .posx_in(posx_in), .speedup(speedup),
    .mueva(mueva), .dir(dir), .bajar(bajar), .period(period), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: tracks the absolute cycle of the next strobe rather than a countdown.
  logic [31:0] exp_q[$];
  bit model_ok = 0;
  bit m_run    = 0;
  bit m_drop   = 0;
  bit m_dir    = 0;
  int m_per    = BASE;
  int m_next   = 0;
  int p_old;
  bit e_mueva  = 0;
  bit e_bajar  = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_run = 0; m_drop = 0; m_dir = 0; m_per = BASE;
      e_mueva = 0; e_bajar = 0; model_ok = 1;
    end else begin
      p_old   = m_per;
      e_mueva = 0;
      e_bajar = 0;
      if (m_drop) begin
        m_drop = 0;
        m_run  = enable;
      end else if (m_run) begin
        if (!enable) begin
          m_run = 0;
        end else if (cyc == m_next) begin
          m_next = cyc + p_old;
          if ((!m_dir && int'(posx_in) >= XMAX) || (m_dir && int'(posx_in) <= XMIN)) begin
            e_bajar = 1; m_dir = !m_dir; m_drop = 1;
          end else begin
            e_mueva = 1;
          end
          exp_q.push_back(32'(cyc));
        end
      end else if (enable) begin
        m_run  = 1;
        m_next = cyc + p_old;
      end
      if (speedup) m_per = (m_per - STEP < MINP) ? MINP : m_per - STEP;
    end
  end

  // Scoreboard: every cycle against the model, and every strobe against the queue.
  always @(negedge clk) begin
    if (model_ok) begin
      check("mueva", 32'(mueva), 32'(e_mueva));
      check("bajar", 32'(bajar), 32'(e_bajar));
      check("dir", 32'(dir), 32'(m_dir));
      check("period", 32'(period), 32'(m_per));
      if (mueva || bajar) begin
        if (exp_q.size() == 0) check("strobe_unexpected", 32'(cyc), 32'(0));
        else check("strobe_time", 32'(cyc), exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_speedup();
    speedup = 1'b1;
    @(negedge clk);
    speedup = 1'b0;
  endtask

  int e0;

  initial begin
    reset = 1'b1; enable = 1'b0; posx_in = 11'd15; speedup = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mueva", 32'(mueva), 0);
    check("rst_bajar", 32'(bajar), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_period", 32'(period), 8);
    reset = 1'b0; enable = 1'b1;
    e0 = cyc + 1;

    // steady marching
    wait_until(e0 + 8);  check("m8", 32'(mueva), 1);
    wait_until(e0 + 16); check("m16", 32'(mueva), 1);
    wait_until(e0 + 24); check("m24", 32'(mueva), 1);
    wait_until(e0 + 26); posx_in = 11'd20;

    // right edge, then left-edge boundary cases
    wait_until(e0 + 32);
    check("drop_r_bajar", 32'(bajar), 1);
    check("drop_r_mueva", 32'(mueva), 0);
    check("drop_r_dir", 32'(dir), 1);
    posx_in = 11'd11;
    wait_until(e0 + 40); check("x11_mueva", 32'(mueva), 1); posx_in = 11'd10;
    wait_until(e0 + 48);
    check("drop_l_bajar", 32'(bajar), 1);
    check("drop_l_dir", 32'(dir), 0);
    posx_in = 11'd19;
    wait_until(e0 + 56); check("x19_mueva", 32'(mueva), 1);

    // speed-ups
    wait_until(e0 + 58); pulse_speedup();
    wait_until(e0 + 60); check("per5", 32'(period), 5);
    wait_until(e0 + 64); check("m64", 32'(mueva), 1);
    wait_until(e0 + 68); pulse_speedup();
    check("m69", 32'(mueva), 1);
    check("per4", 32'(period), 4);
    wait_until(e0 + 74); check("m74_old_spacing", 32'(mueva), 1);
    wait_until(e0 + 78); check("m78", 32'(mueva), 1);
    wait_until(e0 + 79); pulse_speedup();
    check("per_floor", 32'(period), 4);
    wait_until(e0 + 82); check("m82", 32'(mueva), 1);

    // freeze
    wait_until(e0 + 84); enable = 1'b0;
    wait_until(e0 + 86); check("frozen_mueva", 32'(mueva), 0);
    wait_until(e0 + 104); enable = 1'b1;
    wait_until(e0 + 109);
    check("resume_mueva", 32'(mueva), 1);
    check("resume_period", 32'(period), 4);
    wait_until(e0 + 110); posx_in = 11'd20;

    // reset during DROP
    wait_until(e0 + 113);
    check("drop3_bajar", 32'(bajar), 1);
    reset = 1'b1;
    wait_until(e0 + 114);
    check("rst2_bajar", 32'(bajar), 0);
    check("rst2_dir", 32'(dir), 0);
    check("rst2_period", 32'(period), 8);
    reset = 1'b0;

    // enable dropped during DROP
    wait_until(e0 + 123);
    check("drop4_bajar", 32'(bajar), 1);
    enable = 1'b0;
    wait_until(e0 + 124); check("drop4_done", 32'(bajar), 0);
    wait_until(e0 + 140);
    check("idle_dir_kept", 32'(dir), 1);
    check("idle_mueva", 32'(mueva), 0);
    check("strobes_left", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
